// File: rtl/riscv_pma_pkg.sv
// Shared types for the PMA checker and the fetch/data arbiter that feeds it.
package riscv_pma_pkg;

  typedef enum logic [2:0] {
    BYTE  = 3'd0,
    HWORD = 3'd1,
    WORD  = 3'd2,
    DWORD = 3'd3,
    QWORD = 3'd4
  } biu_size_t;

  typedef struct packed {
    logic [1:0] mem_type;
    logic       r;
    logic       w;
    logic       x;
    logic       c;
    logic       cc;
    logic       ri;
    logic       wi;
    logic       m;
    logic [1:0] amo_type;
    logic       a;
  } pmacfg_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_DT = 1'b1
  } pmarb_src_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } pmarb_state_t;

  localparam int STARVE_W = 4;
  localparam int LOCK_W   = 8;

endpackage

// File: rtl/riscv_pma_arbiter.sv
// Arbitrates fetch and data accesses onto one PMA checker; the checker result
// is registered and returned one cycle later tagged with its source.
module riscv_pma_arbiter
  import riscv_pma_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int PLEN         = (XLEN == 32) ? 34 : 56,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_TIMEOUT = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,

  input  logic             if_req_i,
  input  logic [PLEN-1:0]  if_adr_i,
  input  biu_size_t        if_size_i,
  input  logic             if_misaligned_i,
  output logic             if_ack_o,

  input  logic             dt_req_i,
  input  logic [PLEN-1:0]  dt_adr_i,
  input  biu_size_t        dt_size_i,
  input  logic             dt_we_i,
  input  logic             dt_lock_i,
  input  logic             dt_misaligned_i,
  output logic             dt_ack_o,

  output logic             chk_req_o,
  output logic             chk_instruction_o,
  output logic             chk_we_o,
  output logic             chk_lock_o,
  output logic             chk_misaligned_o,
  output logic [PLEN-1:0]  chk_adr_o,
  output biu_size_t        chk_size_o,
  input  pmacfg_t          chk_pma_i,
  input  logic             chk_exception_i,
  input  logic             chk_misaligned_i,
  input  logic             chk_is_cache_i,
  input  logic             chk_is_ext_i,
  input  logic             chk_is_tcm_i,

  output logic             rsp_valid_o,
  output pmarb_src_t       rsp_src_o,
  output pmacfg_t          rsp_pma_o,
  output logic             rsp_exception_o,
  output logic             rsp_misaligned_o,
  output logic             rsp_cache_o,
  output logic             rsp_ext_o,
  output logic             rsp_tcm_o
);

  localparam logic [STARVE_W-1:0] STARVE_LIM_C = STARVE_W'(STARVE_LIMIT);
  localparam logic [LOCK_W-1:0]   LOCK_TO_C    = LOCK_W'(LOCK_TIMEOUT);

  function automatic logic [STARVE_W-1:0] sat_inc_starve(input logic [STARVE_W-1:0] v);
    return (v == {STARVE_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [LOCK_W-1:0] sat_inc_lock(input logic [LOCK_W-1:0] v);
    return (v == {LOCK_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  pmarb_state_t          state;
  logic [STARVE_W-1:0]   starve_cnt;
  logic [LOCK_W-1:0]     lock_cnt;
  logic                  grant_if;
  logic                  grant_dt;
  logic                  grant_any;
  logic [LOCK_W-1:0]     lock_cnt_nxt;

  logic                  vld_p1;
  pmarb_src_t            src_p1;
  pmacfg_t               pma_p1;
  logic                  exception_p1;
  logic                  misaligned_p1;
  logic                  cache_p1;
  logic                  ext_p1;
  logic                  tcm_p1;

  // Stage p0: combinational grant and checker drive
  always_comb begin
    grant_if = 1'b0;
    grant_dt = 1'b0;
    if (!rst_i && !flush_i) begin
      if (state == ARB_LOCKED) begin
        grant_dt = dt_req_i;
      end else if (if_req_i && dt_req_i) begin
        if (starve_cnt == STARVE_LIM_C) grant_if = 1'b1;
        else                            grant_dt = 1'b1;
      end else begin
        grant_if = if_req_i;
        grant_dt = dt_req_i;
      end
    end
  end

  assign grant_any    = grant_if | grant_dt;
  assign lock_cnt_nxt = sat_inc_lock(lock_cnt);

  assign if_ack_o          = grant_if;
  assign dt_ack_o          = grant_dt;
  assign chk_req_o         = grant_any;
  assign chk_instruction_o = grant_if;
  assign chk_we_o          = grant_dt & dt_we_i;
  assign chk_lock_o        = grant_dt & dt_lock_i;
  assign chk_misaligned_o  = grant_if ? if_misaligned_i : dt_misaligned_i;
  assign chk_adr_o         = grant_if ? if_adr_i : dt_adr_i;
  assign chk_size_o        = grant_if ? if_size_i : dt_size_i;

  // Stage p1: registered checker result plus arbitration state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ARB_IDLE;
      starve_cnt    <= '0;
      lock_cnt      <= '0;
      vld_p1        <= 1'b0;
      src_p1        <= SRC_IF;
      pma_p1        <= '0;
      exception_p1  <= 1'b0;
      misaligned_p1 <= 1'b0;
      cache_p1      <= 1'b0;
      ext_p1        <= 1'b0;
      tcm_p1        <= 1'b0;
    end else begin
      vld_p1 <= grant_any;
      if (grant_any) begin
        src_p1        <= grant_if ? SRC_IF : SRC_DT;
        pma_p1        <= chk_pma_i;
        exception_p1  <= chk_exception_i;
        misaligned_p1 <= chk_misaligned_i;
        cache_p1      <= chk_is_cache_i;
        ext_p1        <= chk_is_ext_i;
        tcm_p1        <= chk_is_tcm_i;
      end

      if (flush_i) begin
        state      <= ARB_IDLE;
        starve_cnt <= '0;
        lock_cnt   <= '0;
      end else begin
        case (state)
          ARB_IDLE: begin
            lock_cnt <= '0;
            if (if_req_i && dt_req_i)
              starve_cnt <= grant_if ? '0 : sat_inc_starve(starve_cnt);
            else
              starve_cnt <= '0;
            if (grant_dt && dt_lock_i && !chk_exception_i)
              state <= ARB_LOCKED;
          end
          ARB_LOCKED: begin
            // A faulting locked access cannot leave the sequence open.
            if (grant_dt) begin
              lock_cnt <= '0;
              if (!dt_lock_i || chk_exception_i) state <= ARB_IDLE;
            end else if (lock_cnt_nxt >= LOCK_TO_C) begin
              lock_cnt <= '0;
              state    <= ARB_IDLE;
            end else begin
              lock_cnt <= lock_cnt_nxt;
            end
          end
          default: state <= ARB_IDLE;
        endcase
      end
    end
  end

  assign rsp_valid_o      = vld_p1;
  assign rsp_src_o        = src_p1;
  assign rsp_pma_o        = pma_p1;
  assign rsp_exception_o  = exception_p1;
  assign rsp_misaligned_o = misaligned_p1;
  assign rsp_cache_o      = cache_p1;
  assign rsp_ext_o        = ext_p1;
  assign rsp_tcm_o        = tcm_p1;

endmodule

// File: doc/riscv_pma_arbiter.md
Name: riscv_pma_arbiter

Overview:
- Shares one Physical Memory Attributes checker between the instruction-fetch port and the data (load/store/AMO) port.
- Arbitrates requests each cycle and drives the checker's access inputs combinationally. Checker results are registered and returned one cycle later, tagged with their source.
- Supports locked AMO sequences, starvation protection for fetch, and pipeline flush.
- Sits between IF/LSU front-ends and a single checker instance in the memory subsystem.

Parameters:
- XLEN, 32, architectural width.
- PLEN, 34 when XLEN==32 else 56, physical address width.
- STARVE_LIMIT, 4, maximum consecutive data grants while fetch waits; range 1..15.
- LOCK_TIMEOUT, 8, idle cycles in LOCKED before forced release; range 1..255.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  cancel pending response, release lock
- if_req_i  in  1  fetch request; held until if_ack_o
- if_adr_i  in  PLEN  fetch physical address
- if_size_i  in  biu_size_t  fetch size
- if_misaligned_i  in  1  fetch misaligned
- if_ack_o  out  1  fetch granted this cycle
- dt_req_i  in  1  data request; held until dt_ack_o
- dt_adr_i  in  PLEN  data address
- dt_size_i  in  biu_size_t  data size
- dt_we_i  in  1  write
- dt_lock_i  in  1  AMO/locked access
- dt_misaligned_i  in  1  data misaligned
- dt_ack_o  out  1  data granted this cycle
- chk_req_o, chk_instruction_o, chk_we_o, chk_lock_o, chk_misaligned_o  out  1 each  to checker
- chk_adr_o  out  PLEN; chk_size_o  out  biu_size_t  to checker
- chk_pma_i  in  pmacfg_t  checker attribute result
- chk_exception_i, chk_misaligned_i, chk_is_cache_i, chk_is_ext_i, chk_is_tcm_i  in  1 each  checker flags
- rsp_valid_o  out  1  registered result valid
- rsp_src_o  out  pmarb_src_t  SRC_IF / SRC_DT
- rsp_pma_o  out  pmacfg_t  registered attributes
- rsp_exception_o, rsp_misaligned_o, rsp_cache_o, rsp_ext_o, rsp_tcm_o  out  1 each  registered flags

Behaviour:
- Reset: all registered outputs 0, rsp_pma_o all-zero, state IDLE, starve_cnt 0, lock_cnt 0. Reset applied mid-operation discards any pending response. Reset overrides flush_i.
- Grant is combinational in cycle N: at most one of if_ack_o/dt_ack_o is high. chk_* mirrors the winner; chk_instruction_o=1 for fetch; chk_we_o and chk_lock_o are 0 for fetch. chk_req_o=0 with no grant, and chk_* data is then don't-care.
- Response: cycle N+1 rsp_valid_o=1 with the cycle-N checker outputs captured. Latency 1. One grant per cycle gives full throughput.
- flush_i=1: no grant that cycle; rsp_valid_o=0 next cycle; state->IDLE; starve_cnt, lock_cnt cleared.
- Arbitration in IDLE:
  - Both requesting and starve_cnt==STARVE_LIMIT: grant IF, starve_cnt=0.
  - Both requesting, otherwise: grant DT, starve_cnt++ (saturating).
  - Only IF: grant IF, starve_cnt=0.
  - Only DT: grant DT, starve_cnt=0.
  - None: starve_cnt=0.
- IDLE->LOCKED: DT granted with dt_lock_i=1 and chk_exception_i=0.
- LOCKED:
  - IF is never granted; starve_cnt is held.
  - DT granted with dt_lock_i=0: ->IDLE, same cycle the access is checked.
  - DT granted with dt_lock_i=1: stays LOCKED, lock_cnt=0.
  - No dt_req_i: lock_cnt++; when lock_cnt reaches LOCK_TIMEOUT, ->IDLE and lock_cnt=0.
  - Locked DT access that raises chk_exception_i: ->IDLE.
- A requester dropping req without ack is legal: no grant, no response.
- Widths: starve_cnt 4 bits; lock_cnt 8 bits. Both saturate and never wrap.

Decomposition:
- riscv_pma_pkg gains:
  - pmarb_src_t enum (SRC_IF=0, SRC_DT=1)
  - pmarb_state_t enum (ARB_IDLE, ARB_LOCKED)
- No sub-module. The checker is instantiated beside this block by the parent, not inside it.

Test Plan:
- Reset then IF-only request at adr 0x1000, size WORD, checker returns exception=0 and cache=1 -> if_ack_o=1 in cycle 0; rsp_valid_o=1, rsp_src_o=SRC_IF, rsp_cache_o=1 in cycle 1.
- IF and DT both requesting continuously, STARVE_LIMIT=4 -> grant sequence DT,DT,DT,DT,IF,DT,DT,DT,DT,IF.
- DT lock_i=1 granted with no exception, then DT idle while IF requests -> IF not acked for 8 cycles, IF acked on cycle 9.
- LOCKED, then DT access with lock_i=0 -> granted, state IDLE, next-cycle IF granted when both request and starve_cnt<limit? No: DT wins; IF wins only when alone.
- flush_i asserted in the cycle after a grant -> rsp_valid_o=0 the following cycle, no ack during the flush cycle, state IDLE.
- rst_i asserted while LOCKED with a response pending -> next cycle all outputs 0 and the IF-only request is granted.
